// File: rtl/writeback_unit_if.sv
// Writeback-stage bus: control/data from the pipeline and register-file,
// HI/LO, forwarding and retire-count results back out.
interface writeback_unit_if #(
   parameter int unsigned CNT_W = 32
);
   logic              RegWrite;
   logic              CondWrite;
   logic              flag;
   logic              WriteMem;
   logic              sumOO;
   logic              WriteLo;
   logic              WriteALU;
   logic              HiLoWrite;
   logic [4:0]        Write_Reg;
   logic [31:0]       HI;
   logic [31:0]       LO;
   logic [31:0]       MEM_DATA;
   logic [31:0]       WADDY_VAL;
   logic [31:0]       sumOut;

   logic              RF_WE;
   logic [4:0]        RF_WADDR;
   logic [31:0]       RF_WDATA;
   logic [31:0]       HI_REG;
   logic [31:0]       LO_REG;
   logic              FWD_VALID;
   logic [4:0]        FWD_REG;
   logic [31:0]       FWD_DATA;
   logic [CNT_W-1:0]  RetireCount;

   modport master (
      output RegWrite, CondWrite, flag, WriteMem, sumOO, WriteLo, WriteALU,
             HiLoWrite, Write_Reg, HI, LO, MEM_DATA, WADDY_VAL, sumOut,
      input  RF_WE, RF_WADDR, RF_WDATA, HI_REG, LO_REG, FWD_VALID, FWD_REG,
             FWD_DATA, RetireCount
   );

   modport slave (
      input  RegWrite, CondWrite, flag, WriteMem, sumOO, WriteLo, WriteALU,
             HiLoWrite, Write_Reg, HI, LO, MEM_DATA, WADDY_VAL, sumOut,
      output RF_WE, RF_WADDR, RF_WDATA, HI_REG, LO_REG, FWD_VALID, FWD_REG,
             FWD_DATA, RetireCount
   );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: selects GPR write data, drives the register-file write port,
// holds HI/LO, tracks the last committed write for forwarding, counts retirements.
module writeback_unit #(
   parameter int unsigned CNT_W = 32
) (
   input logic              Clk,
   input logic              Reset,
   writeback_unit_if.slave  wb
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;

   logic              commit_c;
   logic              retire_c;
   logic [DATA_W-1:0] hi_val_c;
   logic [DATA_W-1:0] lo_val_c;
   logic [DATA_W-1:0] sel_data_c;

   logic              rf_we_q,    rf_we_d;
   logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic [DATA_W-1:0] hi_q,       hi_d;
   logic [DATA_W-1:0] lo_q,       lo_d;
   logic              fwd_vld_q,  fwd_vld_d;
   logic [REG_W-1:0]  fwd_reg_q,  fwd_reg_d;
   logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;

   // HI/LO bypass so mfhi/mflo see a same-cycle mult/madd completion
   always_comb begin
      hi_val_c = wb.HiLoWrite ? wb.HI : hi_q;
      lo_val_c = wb.HiLoWrite ? wb.LO : lo_q;
      if (wb.WriteMem)      sel_data_c = wb.MEM_DATA;
      else if (wb.sumOO)    sel_data_c = wb.sumOut;
      else if (wb.WriteLo)  sel_data_c = lo_val_c;
      else if (wb.WriteALU) sel_data_c = wb.WADDY_VAL;
      else                  sel_data_c = hi_val_c;
   end

   // GPR 0 and failed conditional moves behave as if no instruction were present
   assign commit_c = wb.RegWrite && (!wb.CondWrite || wb.flag) && (wb.Write_Reg != '0);
   assign retire_c = commit_c || wb.HiLoWrite;

   always_comb begin
      rf_we_d    = commit_c;
      rf_waddr_d = wb.Write_Reg;
      rf_wdata_d = sel_data_c;
      hi_d       = hi_q;
      lo_d       = lo_q;
      fwd_vld_d  = fwd_vld_q;
      fwd_reg_d  = fwd_reg_q;
      fwd_data_d = fwd_data_q;
      cnt_d      = cnt_q;
      if (wb.HiLoWrite) begin
         hi_d = wb.HI;
         lo_d = wb.LO;
      end
      if (commit_c) begin
         fwd_vld_d  = 1'b1;
         fwd_reg_d  = wb.Write_Reg;
         fwd_data_d = sel_data_c;
      end
      if (retire_c) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         fwd_vld_q  <= 1'b0;
         fwd_reg_q  <= '0;
         fwd_data_q <= '0;
         cnt_q      <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         fwd_vld_q  <= fwd_vld_d;
         fwd_reg_q  <= fwd_reg_d;
         fwd_data_q <= fwd_data_d;
         cnt_q      <= cnt_d;
      end
   end

   assign wb.RF_WE       = rf_we_q;
   assign wb.RF_WADDR    = rf_waddr_q;
   assign wb.RF_WDATA    = rf_wdata_q;
   assign wb.HI_REG      = hi_q;
   assign wb.LO_REG      = lo_q;
   assign wb.FWD_VALID   = fwd_vld_q;
   assign wb.FWD_REG     = fwd_reg_q;
   assign wb.FWD_DATA    = fwd_data_q;
   assign wb.RetireCount = cnt_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus randomized traffic against
// a cycle-level behavioural model of the writeback rules.
module tb_writeback_unit;
   localparam int unsigned CW = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   writeback_unit_if #(.CNT_W(CW)) wb();

   writeback_unit #(.CNT_W(CW)) dut (
      .Clk   (clk),
      .Reset (rst),
      .wb    (wb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: what each output should show after the last edge
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic        m_fv;
   logic [4:0]  m_freg;
   logic [31:0] m_fdata;
   int          m_cnt;

   task automatic clear_inputs();
      wb.RegWrite = 0; wb.CondWrite = 0; wb.flag = 0; wb.WriteMem = 0;
      wb.sumOO = 0; wb.WriteLo = 0; wb.WriteALU = 0; wb.HiLoWrite = 0;
      wb.Write_Reg = 0; wb.HI = 0; wb.LO = 0; wb.MEM_DATA = 0;
      wb.WADDY_VAL = 0; wb.sumOut = 0;
   endtask

   // Advance one clock; the model applies the instruction-level rules to the
   // inputs presented during this cycle.
   task automatic tick();
      bit          commit;
      bit          cond_ok;
      logic [31:0] hv, lv, d;
      cond_ok = !wb.CondWrite || wb.flag;
      commit  = wb.RegWrite && cond_ok && (wb.Write_Reg != 5'd0);
      hv = wb.HiLoWrite ? wb.HI : m_hi;
      lv = wb.HiLoWrite ? wb.LO : m_lo;
      if (wb.WriteMem)      d = wb.MEM_DATA;
      else if (wb.sumOO)    d = wb.sumOut;
      else if (wb.WriteLo)  d = lv;
      else if (wb.WriteALU) d = wb.WADDY_VAL;
      else                  d = hv;
      @(posedge clk);
      if (rst) begin
         m_we = 0; m_waddr = 0; m_wdata = 0; m_hi = 0; m_lo = 0;
         m_fv = 0; m_freg = 0; m_fdata = 0; m_cnt = 0;
      end else begin
         m_we = commit; m_waddr = wb.Write_Reg; m_wdata = d;
         if (wb.HiLoWrite) begin m_hi = wb.HI; m_lo = wb.LO; end
         if (commit) begin m_fv = 1; m_freg = wb.Write_Reg; m_fdata = d; end
         if (commit || wb.HiLoWrite) m_cnt = (m_cnt + 1) % (1 << CW);
      end
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 0;
      wb.RegWrite = 1; wb.WriteALU = 1; wb.Write_Reg = 5'd3; wb.WADDY_VAL = 32'hDEAD_BEEF;
      wb.HiLoWrite = 1; wb.HI = 32'h1111_2222; wb.LO = 32'h3333_4444;
      tick();
      rst = 1;
      wb.Write_Reg = 5'd6; wb.WADDY_VAL = 32'h0BAD_F00D;
      tick();
      n_checks++; if (wb.RF_WE !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", wb.RF_WE); end
      n_checks++; if (wb.RF_WADDR !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", wb.RF_WADDR); end
      n_checks++; if (wb.RF_WDATA !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wb.RF_WDATA); end
      n_checks++; if (wb.HI_REG !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", wb.HI_REG); end
      n_checks++; if (wb.LO_REG !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", wb.LO_REG); end
      n_checks++; if (wb.FWD_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %0b want 0", wb.FWD_VALID); end
      n_checks++; if (wb.FWD_REG !== 5'd0) begin n_fail++; $display("FAIL reset_freg: got %0d want 0", wb.FWD_REG); end
      n_checks++; if (wb.FWD_DATA !== 32'd0) begin n_fail++; $display("FAIL reset_fdata: got %h want 0", wb.FWD_DATA); end
      n_checks++; if (wb.RetireCount !== CW'(0)) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", wb.RetireCount); end
      rst = 0;
      clear_inputs();
      wb.RegWrite = 1; wb.WriteALU = 1; wb.Write_Reg = 5'd4; wb.WADDY_VAL = 32'h55;
      tick();
      n_checks++; if (wb.RF_WE !== 1'b1) begin n_fail++; $display("FAIL post_reset_we: got %0b want 1", wb.RF_WE); end
      n_checks++; if (wb.RF_WADDR !== 5'd4) begin n_fail++; $display("FAIL post_reset_waddr: got %0d want 4", wb.RF_WADDR); end
      n_checks++; if (wb.RetireCount !== CW'(1)) begin n_fail++; $display("FAIL post_reset_cnt: got %0d want 1", wb.RetireCount); end
   endtask

   task automatic test_alu_commit();
      logic [CW-1:0] c0;
      rst = 1; clear_inputs(); tick(); rst = 0;
      wb.RegWrite = 1; wb.WriteALU = 1; wb.Write_Reg = 5'd5; wb.WADDY_VAL = 32'h0000_1234;
      tick();
      n_checks++; if (wb.RF_WE !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %0b want 1", wb.RF_WE); end
      n_checks++; if (wb.RF_WADDR !== 5'd5) begin n_fail++; $display("FAIL alu_waddr: got %0d want 5", wb.RF_WADDR); end
      n_checks++; if (wb.RF_WDATA !== 32'h1234) begin n_fail++; $display("FAIL alu_wdata: got %h want 1234", wb.RF_WDATA); end
      n_checks++; if (wb.FWD_VALID !== 1'b1) begin n_fail++; $display("FAIL alu_fv: got %0b want 1", wb.FWD_VALID); end
      n_checks++; if (wb.RetireCount !== CW'(1)) begin n_fail++; $display("FAIL alu_cnt: got %0d want 1", wb.RetireCount); end
      c0 = wb.RetireCount;
      clear_inputs(); wb.WADDY_VAL = 32'h9999;
      tick();
      n_checks++; if (wb.RF_WE !== 1'b0) begin n_fail++; $display("FAIL alu_idle_we: got %0b want 0", wb.RF_WE); end
      n_checks++; if (wb.FWD_DATA !== 32'h1234) begin n_fail++; $display("FAIL alu_hold_fdata: got %h want 1234", wb.FWD_DATA); end
      n_checks++; if (wb.FWD_REG !== 5'd5) begin n_fail++; $display("FAIL alu_hold_freg: got %0d want 5", wb.FWD_REG); end
      n_checks++; if (wb.RetireCount !== c0) begin n_fail++; $display("FAIL alu_idle_cnt: got %0d want %0d", wb.RetireCount, c0); end
   endtask

   task automatic test_priority();
      clear_inputs();
      wb.RegWrite = 1; wb.Write_Reg = 5'd10;
      wb.WriteMem = 1; wb.WriteALU = 1; wb.sumOO = 1;
      wb.MEM_DATA = 32'hAAAA_0000; wb.WADDY_VAL = 32'h5555; wb.sumOut = 32'h7777;
      tick();
      n_checks++; if (wb.RF_WDATA !== 32'hAAAA_0000) begin n_fail++; $display("FAIL prio_mem: got %h want aaaa0000", wb.RF_WDATA); end
      wb.WriteMem = 0;
      tick();
      n_checks++; if (wb.RF_WDATA !== 32'h7777) begin n_fail++; $display("FAIL prio_sum: got %h want 7777", wb.RF_WDATA); end
      wb.sumOO = 0;
      tick();
      n_checks++; if (wb.RF_WDATA !== 32'h5555) begin n_fail++; $display("FAIL prio_alu: got %h want 5555", wb.RF_WDATA); end
      wb.WriteALU = 0;
      tick();
      n_checks++; if (wb.RF_WDATA !== m_hi) begin n_fail++; $display("FAIL prio_mfhi: got %h want %h", wb.RF_WDATA, m_hi); end
   endtask

   task automatic test_cond();
      logic [CW-1:0] c0;
      clear_inputs();
      c0 = wb.RetireCount;
      wb.RegWrite = 1; wb.CondWrite = 1; wb.flag = 0; wb.Write_Reg = 5'd7; wb.WriteALU = 1;
      wb.WADDY_VAL = 32'hC0DE;
      tick();
      n_checks++; if (wb.RF_WE !== 1'b0) begin n_fail++; $display("FAIL cond_f0_we: got %0b want 0", wb.RF_WE); end
      n_checks++; if (wb.RetireCount !== c0) begin n_fail++; $display("FAIL cond_f0_cnt: got %0d want %0d", wb.RetireCount, c0); end
      n_checks++; if (wb.FWD_REG === 5'd7) begin n_fail++; $display("FAIL cond_f0_freg: got %0d want not 7", wb.FWD_REG); end
      wb.flag = 1;
      tick();
      n_checks++; if (wb.RF_WE !== 1'b1) begin n_fail++; $display("FAIL cond_f1_we: got %0b want 1", wb.RF_WE); end
      n_checks++; if (wb.RF_WADDR !== 5'd7) begin n_fail++; $display("FAIL cond_f1_waddr: got %0d want 7", wb.RF_WADDR); end
      n_checks++; if (wb.RetireCount !== CW'(c0 + 1)) begin n_fail++; $display("FAIL cond_f1_cnt: got %0d want %0d", wb.RetireCount, CW'(c0 + 1)); end
   endtask

   task automatic test_hilo();
      logic [CW-1:0] c0;
      clear_inputs();
      c0 = wb.RetireCount;
      wb.HiLoWrite = 1; wb.HI = 32'h1; wb.LO = 32'hFFFF_FFFE;
      wb.RegWrite = 1; wb.WriteLo = 1; wb.Write_Reg = 5'd9;
      tick();
      n_checks++; if (wb.HI_REG !== 32'h1) begin n_fail++; $display("FAIL hilo_hi: got %h want 1", wb.HI_REG); end
      n_checks++; if (wb.LO_REG !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL hilo_lo: got %h want fffffffe", wb.LO_REG); end
      n_checks++; if (wb.RF_WDATA !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL hilo_bypass: got %h want fffffffe", wb.RF_WDATA); end
      n_checks++; if (wb.RetireCount !== CW'(c0 + 1)) begin n_fail++; $display("FAIL hilo_cnt: got %0d want %0d", wb.RetireCount, CW'(c0 + 1)); end
      clear_inputs(); wb.HI = 32'hABCD; wb.LO = 32'hEF01;
      wb.RegWrite = 1; wb.Write_Reg = 5'd11;
      tick();
      n_checks++; if (wb.HI_REG !== 32'h1) begin n_fail++; $display("FAIL hilo_hold: got %h want 1", wb.HI_REG); end
      n_checks++; if (wb.RF_WDATA !== 32'h1) begin n_fail++; $display("FAIL mfhi_reg: got %h want 1", wb.RF_WDATA); end
   endtask

   task automatic test_reg0_and_wrap();
      logic [CW-1:0] c0;
      logic          fv0;
      logic [31:0]   fd0;
      int            guard;
      clear_inputs();
      c0 = wb.RetireCount; fv0 = wb.FWD_VALID; fd0 = wb.FWD_DATA;
      wb.RegWrite = 1; wb.WriteALU = 1; wb.Write_Reg = 5'd0; wb.WADDY_VAL = 32'h4242;
      tick();
      n_checks++; if (wb.RF_WE !== 1'b0) begin n_fail++; $display("FAIL r0_we: got %0b want 0", wb.RF_WE); end
      n_checks++; if (wb.FWD_VALID !== fv0) begin n_fail++; $display("FAIL r0_fv: got %0b want %0b", wb.FWD_VALID, fv0); end
      n_checks++; if (wb.FWD_DATA !== fd0) begin n_fail++; $display("FAIL r0_fdata: got %h want %h", wb.FWD_DATA, fd0); end
      n_checks++; if (wb.RetireCount !== c0) begin n_fail++; $display("FAIL r0_cnt: got %0d want %0d", wb.RetireCount, c0); end
      wb.Write_Reg = 5'd12;
      guard = 0;
      while (m_cnt != (1 << CW) - 1 && guard < 32) begin tick(); guard++; end
      n_checks++; if (wb.RetireCount !== CW'((1 << CW) - 1)) begin n_fail++; $display("FAIL wrap_pre: got %0d want %0d", wb.RetireCount, (1 << CW) - 1); end
      tick();
      n_checks++; if (wb.RetireCount !== CW'(0)) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", wb.RetireCount); end
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      wb.RegWrite = 1; wb.sumOO = 1;
      for (int i = 0; i < 4; i++) begin
         wb.Write_Reg = 5'(i + 1);
         wb.sumOut = 32'h100 + 32'(i);
         tick();
         n_checks++; if (wb.RF_WE !== 1'b1) begin n_fail++; $display("FAIL b2b_we[%0d]: got %0b want 1", i, wb.RF_WE); end
         n_checks++; if (wb.RF_WDATA !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL b2b_wdata[%0d]: got %h want %h", i, wb.RF_WDATA, 32'h100 + 32'(i)); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         wb.RegWrite  = ($urandom_range(0, 3) != 0);
         wb.CondWrite = ($urandom_range(0, 2) == 0);
         wb.flag      = 1'($urandom);
         wb.WriteMem  = ($urandom_range(0, 4) == 0);
         wb.sumOO     = ($urandom_range(0, 4) == 0);
         wb.WriteLo   = ($urandom_range(0, 3) == 0);
         wb.WriteALU  = 1'($urandom);
         wb.HiLoWrite = ($urandom_range(0, 4) == 0);
         wb.Write_Reg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         wb.HI = $urandom; wb.LO = $urandom; wb.MEM_DATA = $urandom;
         wb.WADDY_VAL = $urandom; wb.sumOut = $urandom;
         rst = ($urandom_range(0, 99) == 0);
         tick();
         n_checks++; if (wb.RF_WE !== m_we) begin n_fail++; $display("FAIL rnd_we[%0d]: got %0b want %0b", i, wb.RF_WE, m_we); end
         n_checks++; if (wb.RF_WADDR !== m_waddr) begin n_fail++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d", i, wb.RF_WADDR, m_waddr); end
         n_checks++; if (wb.RF_WDATA !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, wb.RF_WDATA, m_wdata); end
         n_checks++; if (wb.HI_REG !== m_hi) begin n_fail++; $display("FAIL rnd_hi[%0d]: got %h want %h", i, wb.HI_REG, m_hi); end
         n_checks++; if (wb.LO_REG !== m_lo) begin n_fail++; $display("FAIL rnd_lo[%0d]: got %h want %h", i, wb.LO_REG, m_lo); end
         n_checks++; if (wb.FWD_VALID !== m_fv) begin n_fail++; $display("FAIL rnd_fv[%0d]: got %0b want %0b", i, wb.FWD_VALID, m_fv); end
         n_checks++; if (wb.FWD_REG !== m_freg) begin n_fail++; $display("FAIL rnd_freg[%0d]: got %0d want %0d", i, wb.FWD_REG, m_freg); end
         n_checks++; if (wb.FWD_DATA !== m_fdata) begin n_fail++; $display("FAIL rnd_fdata[%0d]: got %h want %h", i, wb.FWD_DATA, m_fdata); end
         n_checks++; if (wb.RetireCount !== CW'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, wb.RetireCount, m_cnt); end
      end
      rst = 0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_we = 0; m_waddr = 0; m_wdata = 0; m_hi = 0; m_lo = 0;
      m_fv = 0; m_freg = 0; m_fdata = 0; m_cnt = 0;
      clear_inputs();
      rst = 1;
      tick();
      tick();
      test_reset();
      test_alu_commit();
      test_priority();
      test_cond();
      test_hilo();
      test_reg0_and_wrap();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
